cannon_mm_engine: RTL and testbench
===================================

Name: cannon_mm_engine

Overview:
- Parametrised Cannon-algorithm block matrix multiplier: C = A x B for N x N unsigned matrices.
- Work is spread over a Q x Q grid of processing tiles, each holding a BS x BS sub-block.
- Has its own start/busy/out_ready FSM, an initial skew alignment step, and an optional accumulate mode (C += A x B).
- Top-level compute engine; driven by the system controller.

Parameters:
- DW, 32, element width in bits; all arithmetic is modulo 2^DW.
- N, 4, matrix dimension; must be a multiple of Q.
- Q, 2, tile grid dimension (sqrt of tile count, P = Q*Q).
- BS, N/Q, derived local block size; not overridable.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- start  in  1  request a new multiply; sampled only in IDLE or DONE.
- acc_en  in  1  sampled with start; 1 keeps the previous C and adds A x B to it.
- matrix_A  in  DW*N*N  row-major; element (r,c) at bits [(r*N+c)*DW +: DW].
- matrix_B  in  DW*N*N  same layout as matrix_A.
- out  out  DW*N*N  result C, same layout.
- busy  out  1  high in LOAD and COMPUTE.
- out_ready  out  1  high in DONE; out is valid while high.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state=IDLE, busy=0, out_ready=0, all tile registers and accumulators 0, so out=0.
- Reset has priority over everything, including mid-COMPUTE; the in-flight result is discarded.
- States: IDLE -> LOAD -> COMPUTE (Q cycles) -> DONE.
- IDLE/DONE with start=1 -> LOAD.
  - Accumulators are cleared if acc_en=0, retained if acc_en=1.
  - out_ready drops on that same edge.
- start is ignored while busy=1; it is not queued.
- LOAD, one cycle: latch A and B into the tiles with Cannon skew.
  - Tile (i,j) gets A block (i, (i+j) mod Q).
  - Tile (i,j) gets B block ((i+j) mod Q, j).
  - Block element (k,v) of grid block (bi,bj) is global element (bi*BS+k, bj*BS+v).
- COMPUTE, step counter s = 0..Q-1, one cycle per step. Each tile, on the same edge:
  - acc += Ablk x Bblk, the full combinational BS x BS product.
  - A blocks rotate left one tile: tile (i,j) takes from (i,(j+1) mod Q).
  - B blocks rotate up one tile: tile (i,j) takes from ((i+1) mod Q, j).
- After step s=Q-1 -> DONE. out_ready=1 and out holds C until reset or the next accepted start.
- Latency: start sampled at edge k gives LOAD at k+1, COMPUTE at k+2..k+Q+1, out_ready=1 after edge k+Q+2.
- matrix_A/B are sampled only in LOAD; later changes have no effect on the current result.
- Q=1 is legal: a single tile, one COMPUTE step.
- Width rules: products truncated to DW bits; sums wrap modulo 2^DW; no saturation and no overflow flag.
- out mapping: element (bi*BS+k, bj*BS+v) = tile (bi,bj) accumulator element (k,v), wired combinationally from the registers.

Decomposition:
- Package cannon_pkg holds:
  - state enum (IDLE, LOAD, COMPUTE, DONE);
  - function elem_idx(r,c,N) returning the bit offset (r*N+c)*DW;
  - function wrap(x,Q) returning x mod Q.
- One sub-module, tile_mac #(DW,BS):
  - registered A, B and accumulator blocks;
  - load, shift and accumulate enables;
  - combinational BS x BS multiply plus reduction tree.
- The top level holds the FSM, step counter, skew/rotate wiring and output mapping.

Test Plan:
- N=2,Q=2,DW=32: A=[[1,0],[1,1]], B=[[1,0],[1,1]], start, acc_en=0 -> after 4 edges out_ready=1, out=[[1,0],[2,1]]; busy high exactly 3 cycles.
- N=4,Q=2: A=identity, B=elements 1..16 row-major -> out=B exactly. Repeat with acc_en=1 -> out=2*B (2,4,...,32).
- N=2,Q=2,DW=8: A and B all 15 -> every out element = (225+225) mod 256 = 194.
- Assert reset during COMPUTE step 0 -> next edge state IDLE, busy=0, out_ready=0, out all 0. A new start then completes correctly.
- Pulse start during COMPUTE with a different A -> ignored; result equals the first operands, and out_ready still appears at k+Q+2.
- N=3,Q=1: A=[[1,2,3],[4,5,6],[7,8,9]], B=identity -> out=A after 3 edges.

Source files
------------

// File: rtl/cannon_pkg.sv
`default_nettype none
// ============================================================================
// Module     : cannon_pkg
// Purpose    : Shared types and index helpers for the Cannon block-matrix
//              multiplier (state encoding, flat-bus element offsets and
//              modular tile-grid indexing).
// Revision   : 1.0 - initial release
// ============================================================================
package cannon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Bit offset of element (r,c) in a row-major flat N x N bus of dw-bit words.
  function automatic int elem_idx(input int r, input int c, input int n, input int dw);
    return (r * n + c) * dw;
  endfunction

  // Tile-grid coordinate wrap (x mod q).
  function automatic int wrap(input int x, input int q);
    return x % q;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cannon_mm_engine_tile_mac.sv
`default_nettype none
// ============================================================================
// Module     : tile_mac
// Purpose    : One processing tile of the Cannon grid. Holds an A block, a B
//              block and a C accumulator block (each BS x BS, row-major flat).
//              Each step adds the full combinational block product into the
//              accumulator while the A/B blocks take their neighbours' blocks.
// Ports      : clk, reset      - clock, synchronous active-high reset
//              clr_acc         - zero the accumulator block
//              load_en         - latch a_load/b_load (skewed initial blocks)
//              step_en         - accumulate product and take a_in/b_in
//              a_load, b_load  - initial blocks
//              a_in, b_in      - blocks from the right / lower neighbour
//              a_blk, b_blk    - current blocks (to left / upper neighbour)
//              acc             - accumulator block
// Revision   : 1.0 - initial release
// ============================================================================
module tile_mac
  import cannon_pkg::*;
#(
  parameter int DW = 32,
  parameter int BS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr_acc,
  input  logic                  load_en,
  input  logic                  step_en,
  input  logic [DW*BS*BS-1:0]   a_load,
  input  logic [DW*BS*BS-1:0]   b_load,
  input  logic [DW*BS*BS-1:0]   a_in,
  input  logic [DW*BS*BS-1:0]   b_in,
  output logic [DW*BS*BS-1:0]   a_blk,
  output logic [DW*BS*BS-1:0]   b_blk,
  output logic [DW*BS*BS-1:0]   acc
);

  logic [DW*BS*BS-1:0] r_a;
  logic [DW*BS*BS-1:0] r_b;
  logic [DW*BS*BS-1:0] r_acc;
  logic [DW*BS*BS-1:0] w_acc_next;

  // Per output element: dot product of A row k with B column v, truncated
  // to DW bits, then added (modulo 2^DW) to the stored accumulator element.
  for (genvar k = 0; k < BS; k++) begin : g_prod_row
    for (genvar v = 0; v < BS; v++) begin : g_prod_col
      logic [DW-1:0] w_dot;
      always_comb begin
        w_dot = '0;
        for (int m = 0; m < BS; m++) begin
          w_dot = w_dot + DW'(r_a[(k*BS+m)*DW +: DW] * r_b[(m*BS+v)*DW +: DW]);
        end
      end
      assign w_acc_next[(k*BS+v)*DW +: DW] = r_acc[(k*BS+v)*DW +: DW] + w_dot;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
    end else begin
      if (load_en) begin
        r_a <= a_load;
        r_b <= b_load;
      end else if (step_en) begin
        r_a <= a_in;
        r_b <= b_in;
      end
      if (clr_acc) begin
        r_acc <= '0;
      end else if (step_en) begin
        r_acc <= w_acc_next;
      end
    end
  end

  assign a_blk = r_a;
  assign b_blk = r_b;
  assign acc   = r_acc;

endmodule
`default_nettype wire

// File: rtl/cannon_mm_engine.sv
`default_nettype none
// ============================================================================
// Module     : cannon_mm_engine
// Purpose    : C = A x B (or C += A x B) for N x N unsigned matrices using
//              Cannon's algorithm on a Q x Q grid of tile_mac blocks.
//              Sequence: IDLE -> LOAD (skewed block load) -> COMPUTE (Q steps)
//              -> DONE (result held).
// Ports      : clk, reset        - clock, synchronous active-high reset
//              start, acc_en     - request; acc_en=1 keeps previous C
//              matrix_A/B        - row-major flat operands
//              out               - row-major flat result C
//              busy              - high in LOAD and COMPUTE
//              out_ready         - high in DONE, out valid
// Revision   : 1.0 - initial release
// ============================================================================
module cannon_mm_engine
  import cannon_pkg::*;
#(
  parameter int DW = 32,
  parameter int N  = 4,
  parameter int Q  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              acc_en,
  input  logic [DW*N*N-1:0] matrix_A,
  input  logic [DW*N*N-1:0] matrix_B,
  output logic [DW*N*N-1:0] out,
  output logic              busy,
  output logic              out_ready
);

  localparam int BS = N / Q;
  localparam int BW = DW * BS * BS;
  localparam int SW = (Q > 1) ? $clog2(Q) : 1;
  localparam logic [SW-1:0] c_last_step = SW'(Q - 1);

  state_t        r_state;
  state_t        w_next_state;
  logic [SW-1:0] r_step;
  logic          w_accept;
  logic          w_load_en;
  logic          w_step_en;
  logic          w_clr_acc;

  logic [BW-1:0] w_a_load [Q*Q];
  logic [BW-1:0] w_b_load [Q*Q];
  logic [BW-1:0] w_a_blk  [Q*Q];
  logic [BW-1:0] w_b_blk  [Q*Q];
  logic [BW-1:0] w_acc    [Q*Q];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_step <= '0;
    end else if (r_state == COMPUTE) begin
      r_step <= r_step + 1'b1;
    end else begin
      r_step <= '0;
    end
  end

  always_comb begin
    w_next_state = r_state;
    busy         = 1'b0;
    out_ready    = 1'b0;
    w_accept     = 1'b0;
    w_load_en    = 1'b0;
    w_step_en    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_next_state = LOAD;
        end
      end
      LOAD: begin
        busy         = 1'b1;
        w_load_en    = 1'b1;
        w_next_state = COMPUTE;
      end
      COMPUTE: begin
        busy      = 1'b1;
        w_step_en = 1'b1;
        if (r_step == c_last_step) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        out_ready = 1'b1;
        if (start) begin
          w_accept     = 1'b1;
          w_next_state = LOAD;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Accumulators are zeroed on the accepting edge itself so a fresh multiply
  // starts from 0; with acc_en they keep the previous C.
  assign w_clr_acc = w_accept & ~acc_en;

  for (genvar i = 0; i < Q; i++) begin : g_tile_row
    for (genvar j = 0; j < Q; j++) begin : g_tile_col
      localparam int T  = i * Q + j;
      // Initial skew: tile (i,j) starts with A(i, i+j) and B(i+j, j).
      localparam int SK = wrap(i + j, Q);

      for (genvar k = 0; k < BS; k++) begin : g_elem_row
        for (genvar v = 0; v < BS; v++) begin : g_elem_col
          localparam int E = (k * BS + v) * DW;
          assign w_a_load[T][E +: DW] = matrix_A[elem_idx(i*BS+k, SK*BS+v, N, DW) +: DW];
          assign w_b_load[T][E +: DW] = matrix_B[elem_idx(SK*BS+k, j*BS+v, N, DW) +: DW];
          assign out[elem_idx(i*BS+k, j*BS+v, N, DW) +: DW] = w_acc[T][E +: DW];
        end
      end

      // A rotates left (take from right neighbour), B rotates up (take from below).
      tile_mac #(
        .DW (DW),
        .BS (BS)
      ) u_tile (
        .clk     (clk),
        .reset   (reset),
        .clr_acc (w_clr_acc),
        .load_en (w_load_en),
        .step_en (w_step_en),
        .a_load  (w_a_load[T]),
        .b_load  (w_b_load[T]),
        .a_in    (w_a_blk[i*Q + wrap(j+1, Q)]),
        .b_in    (w_b_blk[wrap(i+1, Q)*Q + j]),
        .a_blk   (w_a_blk[T]),
        .b_blk   (w_b_blk[T]),
        .acc     (w_acc[T])
      );
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cannon_mm_engine.sv
`default_nettype none
// ============================================================================
// Module     : tb_cannon_mm_engine
// Purpose    : Directed self-checking bench for cannon_mm_engine using three
//              configurations: main (DW32,N4,Q2), small (DW8,N2,Q2) and
//              single-tile (DW32,N3,Q1).
// Revision   : 1.0 - initial release
// ============================================================================
module tb_cannon_mm_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic         start_m, acc_m, busy_m, rdy_m;
  logic [511:0] a_m, b_m, out_m;
  logic         start_s, acc_s, busy_s, rdy_s;
  logic [31:0]  a_s, b_s, out_s;
  logic         start_q, acc_q, busy_q, rdy_q;
  logic [287:0] a_q, b_q, out_q;

  int tests = 0;
  int fails = 0;

  cannon_mm_engine #(.DW(32), .N(4), .Q(2)) u_main (
    .clk(clk), .reset(reset), .start(start_m), .acc_en(acc_m),
    .matrix_A(a_m), .matrix_B(b_m), .out(out_m), .busy(busy_m), .out_ready(rdy_m)
  );

  cannon_mm_engine #(.DW(8), .N(2), .Q(2)) u_small (
    .clk(clk), .reset(reset), .start(start_s), .acc_en(acc_s),
    .matrix_A(a_s), .matrix_B(b_s), .out(out_s), .busy(busy_s), .out_ready(rdy_s)
  );

  cannon_mm_engine #(.DW(32), .N(3), .Q(1)) u_q1 (
    .clk(clk), .reset(reset), .start(start_q), .acc_en(acc_q),
    .matrix_A(a_q), .matrix_B(b_q), .out(out_q), .busy(busy_q), .out_ready(rdy_q)
  );

  function automatic logic rdy_of(input int which);
    case (which)
      0:       return rdy_m;
      1:       return rdy_s;
      default: return rdy_q;
    endcase
  endfunction

  function automatic logic busy_of(input int which);
    case (which)
      0:       return busy_m;
      1:       return busy_s;
      default: return busy_q;
    endcase
  endfunction

  // Pulse start for one edge on the selected DUT, then wait (bounded) for
  // out_ready. edges counts clock edges from the accepting edge inclusive.
  task automatic run(input int which, input logic acc, output int edges,
                     output int bc, output logic rdy_after_start);
    @(negedge clk);
    case (which)
      0:       begin start_m = 1'b1; acc_m = acc; end
      1:       begin start_s = 1'b1; acc_s = acc; end
      default: begin start_q = 1'b1; acc_q = acc; end
    endcase
    @(negedge clk);
    start_m = 1'b0; start_s = 1'b0; start_q = 1'b0;
    edges = 1;
    bc = 0;
    rdy_after_start = rdy_of(which);
    while (!rdy_of(which) && edges < 40) begin
      if (busy_of(which)) bc++;
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic set_identity_b();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        a_m[(r*4+c)*32 +: 32] = (r == c) ? 32'd1 : 32'd0;
        b_m[(r*4+c)*32 +: 32] = 32'(r*4 + c + 1);
      end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({out_m, busy_m, rdy_m} !== '0) begin
      fails++;
      $display("FAIL reset_main: busy=%0b rdy=%0b out_nonzero=%0b, want all 0", busy_m, rdy_m, |out_m);
    end
    tests++;
    if ({out_s, busy_s, rdy_s} !== '0) begin
      fails++;
      $display("FAIL reset_small: busy=%0b rdy=%0b out=%h, want all 0", busy_s, rdy_s, out_s);
    end
    tests++;
    if ({out_q, busy_q, rdy_q} !== '0) begin
      fails++;
      $display("FAIL reset_q1: busy=%0b rdy=%0b out_nonzero=%0b, want all 0", busy_q, rdy_q, |out_q);
    end
    reset = 1'b0;
  endtask

  task automatic test_small_product();
    int e, bc; logic r1;
    a_s = {8'd1, 8'd1, 8'd0, 8'd1};   // [[1,0],[1,1]]
    b_s = {8'd1, 8'd1, 8'd0, 8'd1};
    run(1, 1'b0, e, bc, r1);
    tests++;
    if (e !== 4) begin fails++; $display("FAIL small_latency: edges=%0d want 4", e); end
    tests++;
    if (bc !== 3) begin fails++; $display("FAIL small_busy_cycles: got %0d want 3", bc); end
    tests++;
    if (out_s !== {8'd1, 8'd2, 8'd0, 8'd1}) begin
      fails++; $display("FAIL small_product: out=%h want 01020001", out_s);
    end
    tests++;
    if (busy_s !== 1'b0) begin fails++; $display("FAIL small_busy_done: busy=%0b want 0", busy_s); end
  endtask

  task automatic test_wrap();
    int e, bc; logic r1;
    a_s = {4{8'd15}};
    b_s = {4{8'd15}};
    run(1, 1'b0, e, bc, r1);
    tests++;
    if (r1 !== 1'b0) begin fails++; $display("FAIL ready_drop_on_start: rdy=%0b want 0", r1); end
    tests++;
    if (out_s !== {4{8'd194}}) begin fails++; $display("FAIL wrap_dw8: out=%h want c2c2c2c2", out_s); end
  endtask

  task automatic test_identity_acc();
    int e, bc; logic r1;
    logic [511:0] exp2;
    set_identity_b();
    run(0, 1'b0, e, bc, r1);
    tests++;
    if (e !== 4) begin fails++; $display("FAIL identity_latency: edges=%0d want 4", e); end
    tests++;
    if (out_m !== b_m) begin fails++; $display("FAIL identity_product: out=%h want %h", out_m, b_m); end
    for (int i = 0; i < 16; i++) exp2[i*32 +: 32] = 32'((i + 1) * 2);
    run(0, 1'b1, e, bc, r1);
    tests++;
    if (e !== 4) begin fails++; $display("FAIL accumulate_latency: edges=%0d want 4", e); end
    tests++;
    if (out_m !== exp2) begin fails++; $display("FAIL accumulate: out=%h want %h", out_m, exp2); end
  endtask

  task automatic test_general();
    int e, bc; logic r1;
    int sq [16] = '{90, 100, 110, 120, 202, 228, 254, 280,
                    314, 356, 398, 440, 426, 484, 542, 600};
    logic [511:0] exp;
    for (int i = 0; i < 16; i++) begin
      a_m[i*32 +: 32] = 32'(i + 1);
      b_m[i*32 +: 32] = 32'(i + 1);
      exp[i*32 +: 32] = 32'(sq[i]);
    end
    run(0, 1'b0, e, bc, r1);
    tests++;
    if (out_m !== exp) begin fails++; $display("FAIL general_square: out=%h want %h", out_m, exp); end
  endtask

  task automatic test_reset_mid();
    int e, bc; logic r1;
    set_identity_b();
    @(negedge clk);
    start_m = 1'b1; acc_m = 1'b0;
    @(negedge clk);                 // LOAD
    start_m = 1'b0;
    @(negedge clk);                 // COMPUTE step 0
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests++;
    if (busy_m !== 1'b0 || rdy_m !== 1'b0) begin
      fails++; $display("FAIL midreset_flags: busy=%0b rdy=%0b want 0 0", busy_m, rdy_m);
    end
    tests++;
    if (out_m !== '0) begin fails++; $display("FAIL midreset_out: out=%h want 0", out_m); end
    run(0, 1'b0, e, bc, r1);
    tests++;
    if (e !== 4) begin fails++; $display("FAIL after_reset_latency: edges=%0d want 4", e); end
    tests++;
    if (out_m !== b_m) begin fails++; $display("FAIL after_reset_product: out=%h want %h", out_m, b_m); end
  endtask

  task automatic test_start_ignored();
    int e;
    logic [511:0] saved_b;
    set_identity_b();
    saved_b = b_m;
    @(negedge clk);
    start_m = 1'b1; acc_m = 1'b0;
    @(negedge clk);                 // LOAD
    start_m = 1'b0;
    e = 1;
    @(negedge clk);                 // COMPUTE step 0
    e++;
    for (int r = 0; r < 4; r++) a_m[(r*4+r)*32 +: 32] = 32'd2;
    start_m = 1'b1; acc_m = 1'b1;
    @(negedge clk);
    e++;
    start_m = 1'b0; acc_m = 1'b0;
    while (!rdy_m && e < 40) begin
      @(negedge clk);
      e++;
    end
    tests++;
    if (e !== 4) begin fails++; $display("FAIL ignored_start_latency: edges=%0d want 4", e); end
    tests++;
    if (out_m !== saved_b) begin fails++; $display("FAIL ignored_start_result: out=%h want %h", out_m, saved_b); end
  endtask

  task automatic test_q1();
    int e, bc; logic r1;
    logic [287:0] exp2;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        a_q[(r*3+c)*32 +: 32] = 32'(r*3 + c + 1);
        b_q[(r*3+c)*32 +: 32] = (r == c) ? 32'd1 : 32'd0;
        exp2[(r*3+c)*32 +: 32] = 32'((r*3 + c + 1) * 2);
      end
    run(2, 1'b0, e, bc, r1);
    tests++;
    if (e !== 3) begin fails++; $display("FAIL q1_latency: edges=%0d want 3", e); end
    tests++;
    if (bc !== 2) begin fails++; $display("FAIL q1_busy_cycles: got %0d want 2", bc); end
    tests++;
    if (out_q !== a_q) begin fails++; $display("FAIL q1_product: out=%h want %h", out_q, a_q); end
    run(2, 1'b1, e, bc, r1);
    tests++;
    if (out_q !== exp2) begin fails++; $display("FAIL q1_accumulate: out=%h want %h", out_q, exp2); end
  endtask

  initial begin
    reset = 1'b1;
    start_m = 1'b0; acc_m = 1'b0; a_m = '0; b_m = '0;
    start_s = 1'b0; acc_s = 1'b0; a_s = '0; b_s = '0;
    start_q = 1'b0; acc_q = 1'b0; a_q = '0; b_q = '0;
    test_reset();
    test_small_product();
    test_wrap();
    test_identity_acc();
    test_general();
    test_reset_mid();
    test_start_ignored();
    test_q1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
